lcm_engine: RTL and testbench

- Multi-cycle, start/done engine that returns both GCD(a,b) and LCM(a,b) for a pair of unsigned operands.
- Internally runs a binary (Stein) GCD reduction, then computes LCM = (a / g) * b by restoring division and shift-add multiplication.
- It is the expanding counterpart of the existing GCD reducer. Control logic uses it to compute common periods and counter wrap values.

---
 rtl/lcm_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_lcm_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcm_engine.sv
// lcm_engine: multi-cycle start/done engine returning GCD and LCM of two unsigned operands.
// Flow: binary (Stein) GCD reduction, restore the common power of two, divide a by g
// (restoring division), then multiply the quotient by b (shift-add).
module lcm_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 done,
  output logic [WIDTH-1:0]     gcd,
  output logic [2*WIDTH-1:0]   lcm
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StReduce,
    StRestore,
    StDiv,
    StMul,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Latched operands; rb doubles as the multiplier shift register during MUL.
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  // Stein working pair and count of shared factors of two.
  logic [WIDTH-1:0]   u_q, u_d;
  logic [WIDTH-1:0]   v_q, v_d;
  logic [CntW-1:0]    k_q, k_d;
  // Restored GCD, also the divisor.
  logic [WIDTH-1:0]   g_q, g_d;
  // Divider: partial remainder, and dividend shifting out MSB-first while quotient shifts in.
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  // Shared iteration counter for DIV and MUL.
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Multiplier: shifting multiplicand and accumulating product.
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  // Result registers.
  logic [WIDTH-1:0]   gcd_q, gcd_d;
  logic [2*WIDTH-1:0] lcm_q, lcm_d;

  // Datapath step values, computed unconditionally and selected by the FSM.
  logic [WIDTH-1:0]   red_u, red_v;
  logic [CntW-1:0]    red_k;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [2*WIDTH-1:0] mul_prod;

  assign ready = (state_q == StIdle);
  assign done  = (state_q == StDone);
  assign gcd   = gcd_q;
  assign lcm   = lcm_q;

  // One Stein reduction step on the working pair.
  always_comb begin
    red_u = u_q;
    red_v = v_q;
    red_k = k_q;
    unique case ({u_q[0], v_q[0]})
      2'b00: begin
        red_u = u_q >> 1;
        red_v = v_q >> 1;
        red_k = k_q + CntW'(1);
      end
      2'b10: red_v = v_q >> 1;
      2'b01: red_u = u_q >> 1;
      2'b11: begin
        if (u_q > v_q) begin
          red_u = (u_q - v_q) >> 1;
        end else begin
          red_v = (v_q - u_q) >> 1;
        end
      end
      default: ;
    endcase
  end

  // One restoring-division step: bring down the next dividend bit and try to subtract g.
  always_comb begin
    div_trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, g_q};
    if (!div_trial[WIDTH]) begin
      div_rem = div_trial[WIDTH-1:0];
      div_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      div_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // One shift-add multiplication step, consuming the multiplier LSB-first.
  always_comb begin
    mul_prod = prod_q + (rb_q[0] ? mcand_q : '0);
  end

  // Next-state and register-load control.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    u_d     = u_q;
    v_d     = v_q;
    k_d     = k_q;
    g_d     = g_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    gcd_d   = gcd_q;
    lcm_d   = lcm_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ra_d = a;
          rb_d = b;
          u_d  = a;
          v_d  = b;
          k_d  = '0;
          if ((a == '0) || (b == '0)) begin
            // Results are loaded here so they are already valid during the DONE cycle.
            gcd_d   = a | b;
            lcm_d   = '0;
            state_d = StDone;
          end else begin
            state_d = StReduce;
          end
        end
      end

      StReduce: begin
        if (u_q == v_q) begin
          state_d = StRestore;
        end else begin
          u_d = red_u;
          v_d = red_v;
          k_d = red_k;
        end
      end

      StRestore: begin
        g_d     = u_q << k_q;
        rem_d   = '0;
        quo_d   = ra_q;
        cnt_d   = CntW'(WIDTH);
        state_d = StDiv;
      end

      StDiv: begin
        rem_d = div_rem;
        quo_d = div_quo;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          // Remainder is zero by construction; the quotient seeds the multiplier.
          mcand_d = {{WIDTH{1'b0}}, div_quo};
          prod_d  = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StMul;
        end
      end

      StMul: begin
        prod_d  = mul_prod;
        mcand_d = mcand_q << 1;
        rb_d    = rb_q >> 1;
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          gcd_d   = g_q;
          lcm_d   = mul_prod;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous clear; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      u_q     <= '0;
      v_q     <= '0;
      k_q     <= '0;
      g_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      gcd_q   <= '0;
      lcm_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      u_q     <= u_d;
      v_q     <= v_d;
      k_q     <= k_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      gcd_q   <= gcd_d;
      lcm_q   <= lcm_d;
    end
  end

endmodule

// File: tb/tb_lcm_engine.sv
// Self-checking bench for lcm_engine: directed cases plus random pairs against an
// arithmetic reference (Euclid GCD, a/g*b LCM, Stein step count for latency).
module tb_lcm_engine;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           done;
  logic [W-1:0]   gcd;
  logic [2*W-1:0] lcm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcm_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .gcd   (gcd),
    .lcm   (lcm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int ref_lcm(input int x, input int y);
    if (x == 0 || y == 0) return 0;
    return (x / ref_gcd(x, y)) * y;
  endfunction

  // Cycles from accept edge to the done cycle, counting the done cycle itself.
  function automatic int ref_latency(input int x, input int y);
    int u, v, r;
    if (x == 0 || y == 0) return 1;
    u = x;
    v = y;
    r = 1;
    while (u != v) begin
      if (u % 2 == 0 && v % 2 == 0) begin
        u = u / 2;
        v = v / 2;
      end else if (v % 2 == 0) begin
        v = v / 2;
      end else if (u % 2 == 0) begin
        u = u / 2;
      end else if (u > v) begin
        u = (u - v) / 2;
      end else begin
        v = (v - u) / 2;
      end
      r++;
    end
    return r + 2 * W + 2;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(ready), 1);
  endtask

  // Issue one pair, scramble the inputs after accept, and check results, latency,
  // output stability while busy, and the single-cycle done pulse.
  task automatic run_pair(input int x, input int y, input string tag);
    int n;
    bit stable;
    logic [W-1:0] g0;
    logic [2*W-1:0] l0;
    wait_ready(tag);
    a = W'(x);
    b = W'(y);
    start = 1'b1;
    g0 = gcd;
    l0 = lcm;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check({tag, "_busy"}, 32'(ready), 0);
    n = 1;
    stable = 1'b1;
    while (done !== 1'b1 && n < 200) begin
      if (gcd !== g0 || lcm !== l0) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_stable"}, 32'(stable), 1);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_gcd"}, 32'(gcd), ref_gcd(x, y));
    check({tag, "_lcm"}, 32'(lcm), ref_lcm(x, y));
    check({tag, "_latency"}, n, ref_latency(x, y));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 0);
    check({tag, "_rdy_after"}, 32'(ready), 1);
  endtask

  initial begin
    int n, r;
    bit seen;
    int x, y;

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_gcd", 32'(gcd), 0);
    check("rst_lcm", 32'(lcm), 0);

    run_pair(12, 18, "p12_18");
    run_pair(255, 254, "p255_254");
    run_pair(200, 150, "p200_150");
    run_pair(0, 7, "p0_7");
    run_pair(0, 0, "p0_0");
    run_pair(128, 128, "p128_128");
    run_pair(9, 0, "p9_0");

    // Start held high with new operands while busy: only one result, no queued request.
    wait_ready("hold");
    a = 8'd12;
    b = 8'd18;
    start = 1'b1;
    @(negedge clk);
    a = 8'd5;
    b = 8'd7;
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_done", 32'(done), 1);
    check("hold_gcd", 32'(gcd), 6);
    check("hold_lcm", 32'(lcm), 36);
    check("hold_lat", n, ref_latency(12, 18));
    @(negedge clk);
    check("hold_pulse", 32'(done), 0);
    check("hold_ready", 32'(ready), 1);
    @(negedge clk);
    start = 1'b0;
    check("hold_accept2", 32'(ready), 0);
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold2_done", 32'(done), 1);
    check("hold2_gcd", 32'(gcd), 1);
    check("hold2_lcm", 32'(lcm), 35);
    @(negedge clk);

    // Reset during the division phase aborts without a done pulse.
    wait_ready("abort");
    a = 8'd240;
    b = 8'd36;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r = ref_latency(240, 36) - 2 * W - 2;
    // Currently in cycle 1; DIV spans cycles r+2 .. r+1+W.
    repeat (r + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 32'(ready), 1);
    check("abort_done", 32'(done), 0);
    check("abort_gcd", 32'(gcd), 0);
    check("abort_lcm", 32'(lcm), 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("abort_nodone", 32'(seen), 0);
    run_pair(240, 36, "p240_36");

    for (int i = 0; i < 1000; i++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      if (i % 97 == 0) x = 0;
      if (i % 89 == 0) y = x;
      run_pair(x, y, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
